id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 171 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID stage of a 5-stage RV32I pipeline: register file, decode, immediate
// generation, load-use hazard detection and the ID/EX pipeline register.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     instr,
  input  logic [31:0]     pc_n,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            stall_out,
  output logic            ex_valid,
  output logic [31:0]     ex_pc_n,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [31:0]     ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [6:0]      ex_opcode,
  output logic [6:0]      ex_funct7,
  output logic [2:0]      ex_funct3,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_reg_write,
  output logic            ex_alu_src,
  output logic            ex_branch,
  output logic            ex_jump
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic [XLEN-1:0] r_regs [NREGS];

  logic [6:0]      w_opcode;
  logic [4:0]      w_rd, w_rs1, w_rs2;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic [XLEN-1:0] w_rs1_data, w_rs2_data;
  logic [31:0]     w_imm;
  logic            w_valid, w_mem_read, w_mem_write, w_reg_write, w_alu_src, w_branch, w_jump;
  logic            w_uses_rs1, w_uses_rs2, w_stall, w_bubble;

  assign w_opcode = instr[6:0];
  assign w_rd     = instr[11:7];
  assign w_funct3 = instr[14:12];
  assign w_rs1    = instr[19:15];
  assign w_rs2    = instr[24:20];
  assign w_funct7 = instr[31:25];

  // Register file write port; x0 is never written so it always reads back zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (wb_en && wb_rd != 5'd0) begin
      r_regs[wb_rd] <= wb_data;
    end
  end

  // Read ports with same-cycle writeback bypass.
  always_comb begin
    w_rs1_data = r_regs[w_rs1];
    w_rs2_data = r_regs[w_rs2];
    if (w_rs1 == 5'd0) w_rs1_data = '0;
    else if (wb_en && wb_rd == w_rs1) w_rs1_data = wb_data;
    else w_rs1_data = r_regs[w_rs1];
    if (w_rs2 == 5'd0) w_rs2_data = '0;
    else if (wb_en && wb_rd == w_rs2) w_rs2_data = wb_data;
    else w_rs2_data = r_regs[w_rs2];
  end

  // Immediate generation and control decode; unknown opcodes become bubbles.
  always_comb begin
    w_imm = 32'd0;
    {w_valid, w_mem_read, w_mem_write, w_reg_write, w_alu_src, w_branch, w_jump} = 7'b0;
    case (w_opcode)
      OP_LOAD: begin
        w_imm = {{20{instr[31]}}, instr[31:20]};
        {w_valid, w_mem_read, w_reg_write, w_alu_src} = 4'b1111;
      end
      OP_STORE: begin
        w_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        {w_valid, w_mem_write, w_alu_src} = 3'b111;
      end
      OP_R: begin
        w_imm = 32'd0;
        {w_valid, w_reg_write} = 2'b11;
      end
      OP_I: begin
        w_imm = {{20{instr[31]}}, instr[31:20]};
        {w_valid, w_reg_write, w_alu_src} = 3'b111;
      end
      OP_BRANCH: begin
        w_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        {w_valid, w_branch} = 2'b11;
      end
      OP_JAL: begin
        w_imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        {w_valid, w_jump, w_reg_write} = 3'b111;
      end
      OP_JALR: begin
        w_imm = {{20{instr[31]}}, instr[31:20]};
        {w_valid, w_jump, w_reg_write, w_alu_src} = 4'b1111;
      end
      OP_LUI, OP_AUIPC: begin
        w_imm = {instr[31:12], 12'd0};
        {w_valid, w_reg_write, w_alu_src} = 3'b111;
      end
      default: begin
        w_imm = 32'd0;
        {w_valid, w_mem_read, w_mem_write, w_reg_write, w_alu_src, w_branch, w_jump} = 7'b0;
      end
    endcase
  end

  assign w_uses_rs1 = (w_opcode != OP_LUI) && (w_opcode != OP_AUIPC) && (w_opcode != OP_JAL);
  assign w_uses_rs2 = (w_opcode == OP_R) || (w_opcode == OP_STORE) || (w_opcode == OP_BRANCH);

  // Load-use hazard; flush wins and reset masks it entirely.
  assign w_stall = reset && !flush && ex_valid && ex_mem_read && (ex_rd != 5'd0) &&
                   ((w_uses_rs1 && ex_rd == w_rs1) || (w_uses_rs2 && ex_rd == w_rs2));
  assign w_bubble  = flush || w_stall || !w_valid;
  assign stall_out = w_stall;

  // ID/EX pipeline register; data fields latch even for bubbles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      {ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_alu_src, ex_branch, ex_jump} <= 7'b0;
      ex_pc_n     <= 32'd0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= 32'd0;
      ex_rs1      <= 5'd0;
      ex_rs2      <= 5'd0;
      ex_rd       <= 5'd0;
      ex_opcode   <= 7'd0;
      ex_funct7   <= 7'd0;
      ex_funct3   <= 3'd0;
    end else begin
      if (w_bubble) begin
        {ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_alu_src, ex_branch, ex_jump} <= 7'b0;
      end else begin
        {ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_alu_src, ex_branch, ex_jump} <=
          {1'b1, w_mem_read, w_mem_write, w_reg_write, w_alu_src, w_branch, w_jump};
      end
      ex_pc_n     <= pc_n;
      ex_rs1_data <= w_rs1_data;
      ex_rs2_data <= w_rs2_data;
      ex_imm      <= w_imm;
      ex_rs1      <= w_rs1;
      ex_rs2      <= w_rs2;
      ex_rd       <= w_rd;
      ex_opcode   <= w_opcode;
      ex_funct7   <= w_funct7;
      ex_funct3   <= w_funct3;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed table-driven bench for id_ex_stage plus hand sequences for
// load-use stall, flush and mid-stream reset.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr, pc_n, wb_data;
  logic        wb_en, flush;
  logic [4:0]  wb_rd;
  logic        stall_out, ex_valid;
  logic [31:0] ex_pc_n, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [6:0]  ex_opcode, ex_funct7;
  logic [2:0]  ex_funct3;
  logic        ex_mem_read, ex_mem_write, ex_reg_write, ex_alu_src, ex_branch, ex_jump;

  int cmp_cnt = 0;
  int err_cnt = 0;
  logic [31:0] pc_ctr = 32'h0000_1000;

  id_ex_stage #(.XLEN(32), .NREGS(32)) dut (
    .clk(clk), .reset(reset), .instr(instr), .pc_n(pc_n),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .stall_out(stall_out), .ex_valid(ex_valid), .ex_pc_n(ex_pc_n),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_opcode(ex_opcode), .ex_funct7(ex_funct7), .ex_funct3(ex_funct3),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .ex_alu_src(ex_alu_src), .ex_branch(ex_branch), .ex_jump(ex_jump)
  );

  always #5 clk = ~clk;

  // ctrl = {mem_read, mem_write, reg_write, alu_src, branch, jump}
  typedef struct {
    logic [31:0] instr;
    logic        wbe;
    logic [4:0]  wbrd;
    logic [31:0] wbd;
    logic        fl;
    logic        e_stall;
    logic        e_valid;
    logic [5:0]  e_ctrl;
    logic [31:0] e_rs1;
    logic [31:0] e_rs2;
    logic [31:0] e_imm;
    logic [4:0]  e_rd;
    logic        chk_data;
  } vec_t;

  vec_t vt [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] i, input logic we, input logic [4:0] wr,
                              input logic [31:0] wd, input logic f, input logic st,
                              input logic v, input logic [5:0] c, input logic [31:0] r1,
                              input logic [31:0] r2, input logic [31:0] im,
                              input logic [4:0] rd, input logic cd);
    vec_t t;
    t = '{i, we, wr, wd, f, st, v, c, r1, r2, im, rd, cd};
    return t;
  endfunction

  // Drive one cycle at negedge, check stall before the edge and ex_* after it.
  task automatic apply(input vec_t v, input string nm);
    logic [31:0] pc_sent;
    @(negedge clk);
    instr = v.instr; wb_en = v.wbe; wb_rd = v.wbrd; wb_data = v.wbd; flush = v.fl;
    pc_ctr = pc_ctr + 32'd4;
    pc_n = pc_ctr;
    pc_sent = pc_ctr;
    #1;
    chk({nm, ".stall"}, {31'd0, stall_out}, {31'd0, v.e_stall});
    @(posedge clk);
    #1;
    chk({nm, ".valid"}, {31'd0, ex_valid}, {31'd0, v.e_valid});
    chk({nm, ".ctrl"},
        {26'd0, ex_mem_read, ex_mem_write, ex_reg_write, ex_alu_src, ex_branch, ex_jump},
        {26'd0, v.e_ctrl});
    if (v.chk_data) begin
      chk({nm, ".rs1_data"}, ex_rs1_data, v.e_rs1);
      chk({nm, ".rs2_data"}, ex_rs2_data, v.e_rs2);
      chk({nm, ".imm"}, ex_imm, v.e_imm);
      chk({nm, ".rd"}, {27'd0, ex_rd}, {27'd0, v.e_rd});
      chk({nm, ".pc_n"}, ex_pc_n, pc_sent);
      chk({nm, ".fields"}, {7'd0, ex_funct7, ex_rs2, ex_rs1, ex_funct3, ex_opcode},
          {7'd0, v.instr[31:15], v.instr[14:12], v.instr[6:0]});
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, ".ctl_zero"},
        {25'd0, ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_alu_src, ex_branch, ex_jump},
        32'd0);
    chk({nm, ".data_zero"}, ex_rs1_data | ex_rs2_data | ex_imm | ex_pc_n, 32'd0);
    chk({nm, ".idx_zero"}, {5'd0, ex_rs1, ex_rs2, ex_rd, ex_opcode, ex_funct7, ex_funct3}, 32'd0);
  endtask

  initial begin
    reset = 1'b0; instr = 32'h0000_0013; pc_n = 32'd0;
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'hAAAA_AAAA; flush = 1'b0;

    // addi x0 / add x1,x5,x0 / bypass / immediates / every opcode class / x0 and wb_en=0 writes
    vt[0]  = mk(32'h0000_0013, 1'b1, 5'd5, 32'h0000_1234, 1'b0, 1'b0, 1'b1, 6'b001100, 32'h0, 32'h0, 32'h0, 5'd0, 1'b1);
    vt[1]  = mk(32'h0002_80B3, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 6'b001000, 32'h0000_1234, 32'h0, 32'h0, 5'd1, 1'b1);
    vt[2]  = mk(32'h0003_8413, 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 6'b001100, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd8, 1'b1);
    vt[3]  = mk(32'hFFC1_0093, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 6'b001100, 32'h0, 32'h0, 32'hFFFF_FFFC, 5'd1, 1'b1);
    vt[4]  = mk(32'h1234_5037, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 6'b001100, 32'h0, 32'h0, 32'h1234_5000, 5'd0, 1'b1);
    vt[5]  = mk(32'h0053_A423, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 6'b010100, 32'hDEAD_BEEF, 32'h0000_1234, 32'h8, 5'd8, 1'b1);
    vt[6]  = mk(32'hFE72_8CE3, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 6'b000010, 32'h0000_1234, 32'hDEAD_BEEF, 32'hFFFF_FFF8, 5'd25, 1'b1);
    vt[7]  = mk(32'h0100_00EF, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 6'b001001, 32'h0, 32'h0, 32'h10, 5'd1, 1'b1);
    vt[8]  = mk(32'h0000_8067, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 6'b001101, 32'h0, 32'h0, 32'h0, 5'd0, 1'b1);
    vt[9]  = mk(32'h0000_1117, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 6'b001100, 32'h0, 32'h0, 32'h0000_1000, 5'd2, 1'b1);
    vt[10] = mk(32'h0000_007F, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 6'b000000, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
    vt[11] = mk(32'h0000_04B3, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 6'b001000, 32'h0, 32'h0, 32'h0, 5'd9, 1'b1);
    vt[12] = mk(32'h0000_04B3, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 6'b001000, 32'h0, 32'h0, 32'h0, 5'd9, 1'b1);
    vt[13] = mk(32'h0001_8513, 1'b0, 5'd3, 32'h0000_0055, 1'b0, 1'b0, 1'b1, 6'b001100, 32'h0, 32'h0, 32'h0, 5'd10, 1'b1);
    vt[14] = mk(32'h0000_0013, 1'b1, 5'd2, 32'h0000_0100, 1'b0, 1'b0, 1'b1, 6'b001100, 32'h0, 32'h0, 32'h0, 5'd0, 1'b1);
    vt[15] = mk(32'h0000_0000, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 6'b000000, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);

    // Initial reset: two edges with wb_en high, everything must read zero.
    repeat (2) @(posedge clk);
    #1;
    chk("reset.stall", {31'd0, stall_out}, 32'd0);
    chk_all_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 16; i++) apply(vt[i], $sformatf("vec%0d", i));

    // Load-use on rs1 with writeback during the stall cycle.
    apply(mk(32'h0001_2183, 1'b1, 5'd1, 32'h11, 1'b0, 1'b0, 1'b1, 6'b101100, 32'h100, 32'h0, 32'h0, 5'd3, 1'b1), "lu1.lw");
    apply(mk(32'h0011_8233, 1'b1, 5'd3, 32'h77, 1'b0, 1'b1, 1'b0, 6'b000000, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0), "lu1.stall");
    apply(mk(32'h0011_8233, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 6'b001000, 32'h77, 32'h11, 32'h0, 5'd4, 1'b1), "lu1.add");
    // Load-use on rs2.
    apply(mk(32'h0001_2183, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 6'b101100, 32'h100, 32'h0, 32'h0, 5'd3, 1'b1), "lu2.lw");
    apply(mk(32'h0030_8233, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0, 6'b000000, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0), "lu2.stall");
    apply(mk(32'h0030_8233, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 6'b001000, 32'h11, 32'h77, 32'h0, 5'd4, 1'b1), "lu2.add");
    // Load into x0 never stalls; LUI does not use its rs1 field.
    apply(mk(32'h0001_2003, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 6'b101100, 32'h100, 32'h0, 32'h0, 5'd0, 1'b1), "lu3.lw_x0");
    apply(mk(32'h0000_0233, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 6'b001000, 32'h0, 32'h0, 32'h0, 5'd4, 1'b1), "lu3.add");
    apply(mk(32'h0001_2183, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 6'b101100, 32'h100, 32'h0, 32'h0, 5'd3, 1'b1), "lu4.lw");
    apply(mk(32'h0001_82B7, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 6'b001100, 32'h77, 32'h0, 32'h0001_8000, 5'd5, 1'b1), "lu4.lui");
    // Flush during a load-use condition, writeback still happens.
    apply(mk(32'h0001_2183, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 6'b101100, 32'h100, 32'h0, 32'h0, 5'd3, 1'b1), "fl.lw");
    apply(mk(32'h0011_8233, 1'b1, 5'd6, 32'h66, 1'b1, 1'b0, 1'b0, 6'b000000, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0), "fl.flush");
    apply(mk(32'h0003_0593, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 6'b001100, 32'h66, 32'h0, 32'h0, 5'd11, 1'b1), "fl.after");

    // Mid-stream reset with a pending load-use hazard and a writeback.
    apply(mk(32'h0001_2183, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 6'b101100, 32'h100, 32'h0, 32'h0, 5'd3, 1'b1), "rst.lw");
    @(negedge clk);
    reset = 1'b0; instr = 32'h0011_8233; wb_en = 1'b1; wb_rd = 5'd9; wb_data = 32'h99; flush = 1'b0;
    #1;
    chk("rst.stall", {31'd0, stall_out}, 32'd0);
    @(posedge clk);
    #1;
    chk_all_zero("rst");
    @(negedge clk);
    wb_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    apply(mk(32'h0072_8633, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 6'b001000, 32'h0, 32'h0, 32'h0, 5'd12, 1'b1), "rst.read57");
    apply(mk(32'h0004_86B3, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 6'b001000, 32'h0, 32'h0, 32'h0, 5'd13, 1'b1), "rst.read9");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
